// File: rtl/wb_regfile_fwd_pkg.sv
// Shared writeback-side definitions: default widths, MEM/WB control bit indices,
// and the EX operand forwarding select encoding.
package wb_regfile_fwd_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 1;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // The EX/MEM result is newer than the one in writeback, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic exmem_hit, input logic wb_hit);
    if (exmem_hit) return FWD_EXMEM;
    if (wb_hit)    return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/wb_regfile_fwd_if.sv
// Pipeline-side bundle for the writeback/regfile/forwarding block. There is no
// valid/ready handshake: every field is sampled or produced in the cycle it is presented.
interface wb_regfile_fwd_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 1,
  parameter int CNT_W  = 16
);
  logic [1:0]        wb_ctrl;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_alu_data;
  logic [REG_AW-1:0] wb_rd;
  logic              exmem_regwrite;
  logic [REG_AW-1:0] exmem_rd;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] wb_value;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    output wb_ctrl, wb_mem_data, wb_alu_data, wb_rd, exmem_regwrite, exmem_rd,
           id_rs, id_rt, ex_rs, ex_rt,
    input  rs_data, rt_data, fwd_a, fwd_b, wb_value, retired_cnt
  );

  modport slave (
    input  wb_ctrl, wb_mem_data, wb_alu_data, wb_rd, exmem_regwrite, exmem_rd,
           id_rs, id_rt, ex_rs, ex_rt,
    output rs_data, rt_data, fwd_a, fwd_b, wb_value, retired_cnt
  );
endinterface

// File: rtl/wb_regfile_fwd_regfile_2r1w.sv
// Architectural register file: async-reset storage, one write port, two
// combinational read ports that see the in-flight write (write-before-read).
module regfile_2r1w #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/wb_regfile_fwd.sv
// Writeback stage: selects the writeback value, commits it to the register file,
// drives bypassed ID reads and EX forwarding selects, and counts committed writes.
module wb_regfile_fwd
  import wb_regfile_fwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 16
) (
  input logic              clock,
  input logic              reset,
  wb_regfile_fwd_if.slave  bus
);
  logic              regwrite;
  logic [DATA_W-1:0] value;
  logic [CNT_W-1:0]  cnt;

  assign regwrite     = bus.wb_ctrl[WB_REGWRITE];
  assign value        = bus.wb_ctrl[WB_MEMTOREG] ? bus.wb_mem_data : bus.wb_alu_data;
  assign bus.wb_value = value;

  regfile_2r1w #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (regwrite),
    .waddr   (bus.wb_rd),
    .wdata   (value),
    .raddr_a (bus.id_rs),
    .raddr_b (bus.id_rt),
    .rdata_a (bus.rs_data),
    .rdata_b (bus.rt_data)
  );

  assign bus.fwd_a = fwd_sel(bus.exmem_regwrite && (bus.exmem_rd == bus.ex_rs),
                             regwrite && (bus.wb_rd == bus.ex_rs));
  assign bus.fwd_b = fwd_sel(bus.exmem_regwrite && (bus.exmem_rd == bus.ex_rt),
                             regwrite && (bus.wb_rd == bus.ex_rt));

  // Wraps silently modulo 2**CNT_W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (regwrite) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.retired_cnt = cnt;

  // An unknown RegWrite would leave both the register file and the counter undefined.
  a_regwrite_known: assert property (@(posedge clock) disable iff (reset)
    !$isunknown(bus.wb_ctrl[WB_REGWRITE]));

endmodule

// File: tb/tb_wb_regfile_fwd.sv
// Bench for wb_regfile_fwd: directed scenarios plus random cycles checked against
// an array/counter reference model.
module tb_wb_regfile_fwd;
  localparam int DATA_W   = 8;
  localparam int REG_AW   = 1;
  localparam int CNT_W    = 4;
  localparam int NUM_REGS = 2 ** REG_AW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_regfile_fwd_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  wb_regfile_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  int m_regs [NUM_REGS];
  int m_cnt;
  int n_vec;
  int n_bad;

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
    m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] ctrl, input logic [7:0] mem, input logic [7:0] alu,
                       input int rd, input logic exwe, input int exrd,
                       input int idrs, input int idrt, input int exrs, input int exrt);
    bus.wb_ctrl        = ctrl;
    bus.wb_mem_data    = mem;
    bus.wb_alu_data    = alu;
    bus.wb_rd          = REG_AW'(rd);
    bus.exmem_regwrite = exwe;
    bus.exmem_rd       = REG_AW'(exrd);
    bus.id_rs          = REG_AW'(idrs);
    bus.id_rt          = REG_AW'(idrt);
    bus.ex_rs          = REG_AW'(exrs);
    bus.ex_rt          = REG_AW'(exrt);
  endtask

  function automatic int exp_fwd(input int src);
    if (bus.exmem_regwrite && int'(bus.exmem_rd) == src) return 2;
    if (bus.wb_ctrl[1] && int'(bus.wb_rd) == src)        return 1;
    return 0;
  endfunction

  // Check outputs mid-cycle, then let the rising edge commit and mirror it in the model.
  task automatic cycle();
    int wbv, ers, ert;
    @(negedge clock);
    wbv = bus.wb_ctrl[0] ? int'(bus.wb_mem_data) : int'(bus.wb_alu_data);
    ers = (bus.wb_ctrl[1] && bus.wb_rd == bus.id_rs) ? wbv : m_regs[bus.id_rs];
    ert = (bus.wb_ctrl[1] && bus.wb_rd == bus.id_rt) ? wbv : m_regs[bus.id_rt];
    chk("wb_value",    32'(bus.wb_value),    32'(wbv));
    chk("rs_data",     32'(bus.rs_data),     32'(ers));
    chk("rt_data",     32'(bus.rt_data),     32'(ert));
    chk("fwd_a",       32'(bus.fwd_a),       32'(exp_fwd(int'(bus.ex_rs))));
    chk("fwd_b",       32'(bus.fwd_b),       32'(exp_fwd(int'(bus.ex_rt))));
    chk("retired_cnt", 32'(bus.retired_cnt), 32'(m_cnt));
    @(posedge clock);
    if (!reset && bus.wb_ctrl[1]) begin
      m_regs[bus.wb_rd] = wbv;
      m_cnt = (m_cnt + 1) % (2 ** CNT_W);
    end
    #1;
  endtask

  task automatic drive_random(input logic force_we);
    logic [1:0] c;
    c = 2'($urandom_range(0, 3));
    if (force_we) c[1] = 1'b1;
    drive(c, 8'($urandom), 8'($urandom), $urandom_range(0, NUM_REGS - 1),
          1'($urandom_range(0, 1)), $urandom_range(0, NUM_REGS - 1),
          $urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1),
          $urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_bad = 0;
    model_clear();
    drive(2'b10, 8'h11, 8'h22, 1, 1'b0, 0, 0, 1, 0, 0);
    @(posedge clock);
    #1;
    cycle();                      // reset held with RegWrite=1: nothing lands
    reset = 1'b0;

    // ALU writeback to reg1, then read both registers back
    drive(2'b10, 8'hA5, 8'h3C, 1, 1'b0, 0, 0, 1, 0, 0);
    cycle();
    drive(2'b00, 8'h00, 8'h00, 0, 1'b0, 0, 0, 1, 0, 0);
    cycle();

    // Load writeback to reg0 with both ID ports bypassed, then a non-writing MemtoReg cycle
    drive(2'b11, 8'hA5, 8'h3C, 0, 1'b0, 0, 0, 0, 0, 0);
    cycle();
    drive(2'b01, 8'h77, 8'h66, 0, 1'b0, 0, 0, 1, 0, 0);
    cycle();

    // Forward priority: EX/MEM beats WB, then WB alone
    drive(2'b10, 8'h11, 8'h22, 1, 1'b1, 1, 0, 1, 1, 0);
    cycle();
    drive(2'b10, 8'h11, 8'h44, 1, 1'b0, 1, 0, 1, 1, 0);
    cycle();

    // Reset pulse mid-cycle while a write is presented
    drive(2'b10, 8'h55, 8'h99, 1, 1'b0, 0, 0, 1, 1, 1);
    #2;
    reset = 1'b1;
    model_clear();
    cycle();
    reset = 1'b0;
    drive(2'b00, 8'h55, 8'h99, 1, 1'b0, 0, 0, 1, 1, 1);
    cycle();

    // Counter wrap: 2**CNT_W commits return to zero, idle cycles do not count
    for (int i = 0; i < (2 ** CNT_W); i++) begin
      drive_random(1'b1);
      cycle();
    end
    chk("cnt_wrap", 32'(bus.retired_cnt), 32'(0));
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 8'($urandom), 8'($urandom), $urandom_range(0, 1), 1'b0, 0, 0, 1, 0, 1);
      cycle();
    end

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      drive_random(1'b0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
